// File: rtl/sd_track_scheduler.sv
// Round-robin sector sequencer: picks an eligible audio track, reads one SD
// sector for it and steers the 512 bytes into that track's FIFO.
module sd_track_scheduler #(
  parameter int NUM_TRACKS        = 2,
  parameter int SECTORS_PER_TRACK = 22,
  parameter int SECTOR_BYTES      = 512,
  parameter int LOW_WATER         = 1536
) (
  input  logic                     clk_100mhz,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              base_addr,
  input  logic [31:0]              gap,
  input  logic                     sd_ready,
  input  logic                     sd_byte_available,
  input  logic [7:0]               sd_dout,
  input  logic [11*NUM_TRACKS-1:0] fifo_level,
  output logic                     sd_rd,
  output logic [31:0]              sd_addr,
  output logic [NUM_TRACKS-1:0]    fifo_wr_en,
  output logic [7:0]               fifo_din,
  output logic [1:0]               cur_track,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state_dbg
);
  localparam int RW = $clog2(SECTORS_PER_TRACK + 1);
  localparam int BW = $clog2(SECTOR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_READ, S_WAIT_RDY, S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [31:0]           off_q [NUM_TRACKS];
  logic [31:0]           off_d [NUM_TRACKS];
  logic [RW-1:0]         rem_q [NUM_TRACKS];
  logic [RW-1:0]         rem_d [NUM_TRACKS];
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            cur_q, cur_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  sd_rd_q, sd_rd_d;
  logic [31:0]           addr_q, addr_d;
  logic [NUM_TRACKS-1:0] wr_q, wr_d;
  logic [7:0]            din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  avail_q;

  logic                  byte_edge;
  logic                  last_byte;
  logic [NUM_TRACKS-1:0] elig;
  logic                  any_rem;
  logic                  found;
  logic [1:0]            sel;
  logic [2:0]            idx;
  logic [2:0]            ptr_nxt;

  assign byte_edge = sd_byte_available & ~avail_q;
  assign last_byte = (cnt_q == BW'(SECTOR_BYTES - 1));

  // Eligibility and round-robin search starting at the pointer.
  always_comb begin
    elig    = '0;
    any_rem = 1'b0;
    found   = 1'b0;
    sel     = ptr_q;
    idx     = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      elig[t] = (rem_q[t] != '0) && (fifo_level[11*t +: 11] <= 11'(LOW_WATER));
      if (rem_q[t] != '0) any_rem = 1'b1;
    end
    for (int i = 0; i < NUM_TRACKS; i++) begin
      idx = {1'b0, ptr_q} + 3'(i);
      if (idx >= 3'(NUM_TRACKS)) idx = idx - 3'(NUM_TRACKS);
      for (int t = 0; t < NUM_TRACKS; t++) begin
        if (!found && (3'(t) == idx) && elig[t]) begin
          found = 1'b1;
          sel   = 2'(t);
        end
      end
    end
    ptr_nxt = {1'b0, cur_q} + 3'd1;
    if (ptr_nxt >= 3'(NUM_TRACKS)) ptr_nxt = '0;
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_SELECT;
      S_SELECT:   if (abort || !any_rem) state_d = S_FINISH;
                  else if (found)        state_d = S_ISSUE;
      S_ISSUE:    if (sd_rd_q && !sd_ready) state_d = S_READ;
      S_READ:     if (byte_edge && last_byte) state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (sd_ready) state_d = abort ? S_FINISH : S_SELECT;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    off_d  = off_q;
    rem_d  = rem_q;
    ptr_d  = ptr_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    sd_rd_d = sd_rd_q;
    addr_d = addr_q;
    wr_d   = '0;
    din_d  = din_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int t = 0; t < NUM_TRACKS; t++) begin
            off_d[t] = 32'(t) * gap;
            rem_d[t] = RW'(SECTORS_PER_TRACK);
          end
          busy_d = 1'b1;
        end
      end
      S_SELECT: begin
        if (!abort && any_rem && found) begin
          cur_d = sel;
          for (int t = 0; t < NUM_TRACKS; t++)
            if (2'(t) == sel) addr_d = base_addr + off_q[t];
        end
      end
      S_ISSUE: begin
        // Request only once the controller is idle; drop it once it goes busy.
        if (!sd_rd_q) begin
          if (sd_ready) sd_rd_d = 1'b1;
        end else if (!sd_ready) begin
          sd_rd_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (byte_edge) begin
          din_d = sd_dout;
          cnt_d = cnt_q + BW'(1);
          for (int t = 0; t < NUM_TRACKS; t++) begin
            wr_d[t] = (2'(t) == cur_q);
            if (last_byte && (2'(t) == cur_q)) begin
              off_d[t] = off_q[t] + 32'(SECTOR_BYTES);
              rem_d[t] = rem_q[t] - RW'(1);
            end
          end
          if (last_byte) ptr_d = ptr_nxt[1:0];
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        off_q[t] <= '0;
        rem_q[t] <= '0;
      end
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      sd_rd_q <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      off_q   <= off_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      sd_rd_q <= sd_rd_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      avail_q <= sd_byte_available;
    end
  end

  assign sd_rd      = sd_rd_q;
  assign sd_addr    = addr_q;
  assign fifo_wr_en = wr_q;
  assign fifo_din   = din_q;
  assign cur_track  = cur_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/sd_track_scheduler.md
Name: sd_track_scheduler

Overview:
- Sequences sector reads from the shared sd_controller on behalf of NUM_TRACKS audio tracks. Each track has its own byte FIFO feeding the audio mixer.
- Picks the next track by round-robin among tracks whose FIFO has room for a full sector and that still have sectors left. Drives sd_rd and sd_addr, counts the 512 bytes of each sector, and steers each byte into the selected track's FIFO.
- Sits between the sd_controller (25 MHz, derived synchronously from clk_100mhz) and the per-track fifo_generator_0 instances.

Parameters:
- NUM_TRACKS, 2, number of tracks/FIFOs (1..4).
- SECTORS_PER_TRACK, 22, sectors read per track per playback run.
- SECTOR_BYTES, 512, bytes per SD sector.
- LOW_WATER, 1536, a track is eligible only when its fifo_level <= LOW_WATER (FIFO depth 2048).

Ports:
- clk_100mhz  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run from base_addr
- abort  in  1  level; ends the run at the next sector boundary
- base_addr  in  32  byte address of track 0, sector 0
- gap  in  32  byte spacing between consecutive tracks' start addresses
- sd_ready  in  1  sd_controller ready
- sd_byte_available  in  1  sd_controller byte strobe (level, held across several 100 MHz cycles)
- sd_dout  in  8  sd_controller read data
- fifo_level  in  11*NUM_TRACKS  data_count of each track FIFO; track t occupies bits [11t+10:11t]
- sd_rd  out  1  read request to sd_controller
- sd_addr  out  32  sector byte address to sd_controller
- fifo_wr_en  out  NUM_TRACKS  one-hot write strobe
- fifo_din  out  8  byte for the FIFOs
- cur_track  out  2  track currently being read
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (asynchronous, reset_n=0):
  - outputs: sd_rd=0, sd_addr=0, fifo_wr_en=0, fifo_din=0, cur_track=0, busy=0, done=0.
  - internal: FSM=IDLE, all per-track sector counters=0, round-robin pointer=0, byte counter=0.
- Edge detection: byte_edge = sd_byte_available & ~previous sample (one register, reset 0). Exactly one edge per byte.
- IDLE:
  - start=1 loads per-track offsets off[t] = t*gap and remaining[t] = SECTORS_PER_TRACK, then sets busy=1 and goes to SELECT.
  - start while busy is ignored.
- SELECT:
  - A track is eligible when remaining[t]>0 && fifo_level[t] <= LOW_WATER.
  - Search order starts at the round-robin pointer. First eligible track t: cur_track=t, sd_addr=base_addr+off[t] (32-bit wraparound), go to ISSUE.
  - No track eligible but some remaining>0: stay in SELECT.
  - All remaining==0, or abort=1: go to FINISH.
- ISSUE:
  - sd_rd=1 until sd_ready is sampled 0 (controller accepted), then sd_rd=0, byte counter=0, go to READ.
  - sd_rd is never asserted while sd_ready=0 on entry; ISSUE waits for sd_ready=1 first.
- READ:
  - On each byte_edge, the next cycle has fifo_din=sd_dout and fifo_wr_en[cur_track]=1 for exactly one cycle, and the byte counter increments.
  - After byte SECTOR_BYTES-1 is written: off[cur_track] += SECTOR_BYTES, remaining[cur_track] -= 1, pointer = cur_track+1 mod NUM_TRACKS, go to WAIT_RDY.
- WAIT_RDY:
  - Waits for sd_ready=1.
  - Then goes to SELECT, or to FINISH if abort=1.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- abort during ISSUE/READ has no effect until the sector completes. SD reads are never truncated, and no partial sector is written.
- Bytes always land in the track selected at ISSUE, even if fifo_level changes mid-sector. LOW_WATER guarantees room for one full sector.
- At most one fifo_wr_en bit is high in any cycle.
- Latency: sd_rd rises 1 cycle after entering ISSUE with sd_ready=1. The first FIFO write follows the first byte_edge by 1 cycle.

Test Plan:
- Two tracks, base_addr=0x2C00, gap=0x2C00, both levels 0, start -> sd_addr sequence 0x2C00, 0x5800, 0x2E00, 0x5A00 …, alternating tracks; 44 sectors total; done pulses once; busy=0 afterwards.
- Track 0 level=1600, track 1 level=0 -> only track 1 is serviced. Drop track 0 to 1536 -> track 0 is selected at the next SELECT.
- Each sector model emits 512 byte strobes with data = byte index -> exactly 512 one-cycle fifo_wr_en pulses to the selected track, data 0..255 twice; the other track's strobe stays 0.
- abort asserted at byte 100 of a sector -> remaining 412 bytes are written, no further sd_rd, done=1 after sd_ready returns.
- reset_n pulsed low mid-READ -> all outputs 0 immediately (asynchronously); the next start restarts from base_addr.
- start pulsed while busy -> ignored; addresses unchanged, sector counts unchanged.
